// File: rtl/i2s_tx_serializer_if.sv
// Stereo sample-pair handshake from the DSP core (master) to the I2S transmit serializer (slave).
interface i2s_tx_serializer_if #(
    parameter int DATA_W = 24
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: stereo pairs shifted MSB-first onto sdata, framed by codec lrclk.
// Latency: slot MSB on sdata the cycle after the lrclk change is sampled (I2S one-bit delay).
// Backpressure: one-deep holding register; s_ready low while it is full; late pairs mute and count.
module i2s_tx_serializer #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic               bclk,
    input  logic               resetn,
    input  logic               lrclk,
    i2s_tx_serializer_if.slave s,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun,
    output logic [15:0]        underrun_count
);
    localparam int               CNT_W   = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full;
    logic [DATA_W-1:0] act_r;
    logic [SLOT_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              lr_q;

    logic              accept;
    logic              lr_edge;
    logic              left_edge;
    logic [SLOT_W-1:0] load_word;

    assign s.s_ready = !hold_full;
    assign accept    = s.s_valid && !hold_full;
    assign lr_edge   = (lrclk != lr_q);
    assign left_edge = lr_edge && !lrclk;

    // Left slot takes the held pair (or silence on underrun); right slot replays the latched right sample.
    always_comb begin
        load_word = '0;
        if (left_edge) begin
            if (hold_full) begin
                load_word[SLOT_W-1 -: DATA_W] = hold_l;
            end
        end else begin
            load_word[SLOT_W-1 -: DATA_W] = act_r;
        end
    end

    always_ff @(posedge bclk) begin
        if (!resetn) begin
            hold_l         <= '0;
            hold_r         <= '0;
            hold_full      <= 1'b0;
            act_r          <= '0;
            shreg          <= '0;
            bit_cnt        <= CNT_MAX;
            lr_q           <= lrclk;
            sdata          <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= 16'h0000;
        end else begin
            lr_q        <= lrclk;
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (accept) begin
                hold_l    <= s.s_left;
                hold_r    <= s.s_right;
                hold_full <= 1'b1;
            end

            if (lr_edge) begin
                // MSB goes out now; the register keeps the remaining bits pre-shifted.
                sdata   <= load_word[SLOT_W-1];
                shreg   <= load_word << 1;
                bit_cnt <= CNT_ONE;
                if (left_edge) begin
                    frame_start <= 1'b1;
                    if (hold_full) begin
                        act_r     <= hold_r;
                        hold_full <= 1'b0;
                    end else begin
                        act_r    <= '0;
                        underrun <= 1'b1;
                        if (underrun_count != 16'hFFFF) begin
                            underrun_count <= underrun_count + 16'd1;
                        end
                    end
                end
            end else if (bit_cnt < CNT_MAX) begin
                sdata   <= shreg[SLOT_W-1];
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + CNT_ONE;
            end else begin
                // Slot longer than SLOT_W: pad with zeros until the next edge.
                sdata <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: frames, underruns, backpressure, odd slot lengths, reset, saturation.
module tb_i2s_tx_serializer;
    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;

    logic        bclk   = 1'b0;
    logic        resetn = 1'b0;
    logic        lrclk  = 1'b1;
    logic        sdata;
    logic        frame_start;
    logic        underrun;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q_l[$];
    logic [DATA_W-1:0] q_r[$];

    i2s_tx_serializer_if #(.DATA_W(DATA_W)) s_if ();

    i2s_tx_serializer #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .bclk           (bclk),
        .resetn         (resetn),
        .lrclk          (lrclk),
        .s              (s_if.slave),
        .sdata          (sdata),
        .frame_start    (frame_start),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        q_l.push_back(l);
        q_r.push_back(r);
    endtask

    task automatic offer();
        if (!s_if.s_valid && q_l.size() > 0) begin
            s_if.s_left  = q_l.pop_front();
            s_if.s_right = q_r.pop_front();
            s_if.s_valid = 1'b1;
        end
    endtask

    // One bclk; sample point is 1 time unit after the rising edge. The source advances on acceptance.
    task automatic tick();
        logic fire;
        fire = s_if.s_valid && s_if.s_ready;
        @(posedge bclk);
        #1;
        if (fire) begin
            s_if.s_valid = 1'b0;
            offer();
        end
    endtask

    // Drive lrclk to lr for len bclks and check every serial bit plus the frame/underrun pulses.
    task automatic slot(input logic lr, input int len, input logic [31:0] word,
                        input logic exp_ur, input string tag);
        logic edge_now;
        logic exp_bit;
        edge_now = (lr != lrclk);
        lrclk    = lr;
        for (int i = 0; i < len; i++) begin
            tick();
            exp_bit = (i < 32) ? word[31-i] : 1'b0;
            check($sformatf("%s_sdata_b%0d", tag, i), 32'(sdata), 32'(exp_bit));
            check($sformatf("%s_fs_b%0d", tag, i), 32'(frame_start),
                  32'(i == 0 && edge_now && !lr));
            check($sformatf("%s_ur_b%0d", tag, i), 32'(underrun),
                  32'(i == 0 && edge_now && !lr && exp_ur));
        end
    endtask

    initial begin
        logic [15:0] exp_cnt;
        s_if.s_valid = 1'b0;
        s_if.s_left  = '0;
        s_if.s_right = '0;

        // Reset state
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("rst_sdata", 32'(sdata), 32'h0);
        check("rst_ready", 32'(s_if.s_ready), 32'h1);
        check("rst_count", 32'(underrun_count), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        check("rst_ur", 32'(underrun), 32'h0);

        // Basic frame with a preloaded pair
        push(24'hABCDEF, 24'h123456);
        offer();
        slot(1'b1, 8, 32'h0, 1'b0, "idle");
        check("basic_ready_full", 32'(s_if.s_ready), 32'h0);
        slot(1'b0, 32, 32'hABCDEF00, 1'b0, "basic_l");
        check("basic_ready_free", 32'(s_if.s_ready), 32'h1);
        slot(1'b1, 32, 32'h12345600, 1'b0, "basic_r");

        // Underrun; a pair captured on the same edge transmits one frame later
        push(24'h000111, 24'h000222);
        offer();
        slot(1'b0, 32, 32'h0, 1'b1, "ur_l");
        check("ur_count1", 32'(underrun_count), 32'd1);
        slot(1'b1, 32, 32'h0, 1'b0, "ur_r");
        slot(1'b0, 32, 32'h00011100, 1'b0, "late_l");
        check("late_count", 32'(underrun_count), 32'd1);

        // Backpressure: three pairs with s_valid held high
        push(24'h000001, 24'h000010);
        push(24'h000002, 24'h000020);
        push(24'h000003, 24'h000030);
        offer();
        slot(1'b1, 32, 32'h00022200, 1'b0, "late_r");
        check("bp_ready_low", 32'(s_if.s_ready), 32'h0);
        slot(1'b0, 32, 32'h00000100, 1'b0, "bp1_l");
        slot(1'b1, 32, 32'h00001000, 1'b0, "bp1_r");
        slot(1'b0, 32, 32'h00000200, 1'b0, "bp2_l");
        slot(1'b1, 32, 32'h00002000, 1'b0, "bp2_r");
        slot(1'b0, 32, 32'h00000300, 1'b0, "bp3_l");
        slot(1'b1, 32, 32'h00003000, 1'b0, "bp3_r");
        slot(1'b0, 32, 32'h0, 1'b1, "bp_end_l");
        check("bp_count2", 32'(underrun_count), 32'd2);

        // Long (40) then short (20) slots
        push(24'h800001, 24'h7FFFFF);
        push(24'h800001, 24'h7FFFFF);
        offer();
        slot(1'b1, 32, 32'h0, 1'b0, "bp_end_r");
        slot(1'b0, 40, 32'h80000100, 1'b0, "long_l");
        slot(1'b1, 40, 32'h7FFFFF00, 1'b0, "long_r");
        slot(1'b0, 20, 32'h80000100, 1'b0, "short_l");
        slot(1'b1, 20, 32'h7FFFFF00, 1'b0, "short_r");
        check("short_count", 32'(underrun_count), 32'd2);
        slot(1'b0, 20, 32'h0, 1'b1, "short_end_l");
        check("short_end_count", 32'(underrun_count), 32'd3);

        // Reset at bit 10 of a left slot
        push(24'h5A5A5A, 24'h0F0F0F);
        offer();
        slot(1'b1, 20, 32'h0, 1'b0, "pre_rst_r");
        slot(1'b0, 10, 32'h5A5A5A00, 1'b0, "pre_rst_l");
        resetn = 1'b0;
        tick();
        tick();
        check("mid_rst_sdata", 32'(sdata), 32'h0);
        check("mid_rst_ready", 32'(s_if.s_ready), 32'h1);
        check("mid_rst_count", 32'(underrun_count), 32'h0);
        resetn = 1'b1;
        slot(1'b0, 22, 32'h0, 1'b0, "post_rst_l");
        slot(1'b1, 32, 32'h0, 1'b0, "post_rst_r");
        check("post_rst_ready", 32'(s_if.s_ready), 32'h1);
        check("post_rst_count", 32'(underrun_count), 32'h0);
        slot(1'b0, 32, 32'h0, 1'b1, "post_rst_ur_l");
        check("post_rst_count1", 32'(underrun_count), 32'd1);

        // Saturation: preset the counter near the top, then run minimal frames
        force dut.underrun_count = 16'hFFFD;
        tick();
        release dut.underrun_count;
        tick();
        check("sat_preset", 32'(underrun_count), 32'h0000FFFD);
        for (int k = 0; k < 4; k++) begin
            slot(1'b1, 1, 32'h0, 1'b0, $sformatf("sat_r%0d", k));
            slot(1'b0, 1, 32'h0, 1'b1, $sformatf("sat_l%0d", k));
            exp_cnt = (k < 2) ? 16'(16'hFFFE + k) : 16'hFFFF;
            check($sformatf("sat_count%0d", k), 32'(underrun_count), 32'(exp_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
